// File: rtl/memoria_load_param_pkg.sv
// Shared state encoding and default geometry for the game-state RAM.
package memoria_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam int             DEF_DATA_W     = 2;
  localparam int             DEF_DEPTH      = 16;
  localparam logic [1:0]     DEF_INIT_VALUE = 2'b10;

endpackage

// File: rtl/memoria_load_param_ram_core.sv
// Plain single-port RAM array: one write port, read through a registered address.
module memoria_ram_core
  import memoria_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [ADDR_W-1:0] o_raddr_q,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_raddr_p1;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // stage p1: read address register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_raddr_p1 <= '0;
    else            r_raddr_p1 <= i_raddr;
  end

  assign o_raddr_q = r_raddr_p1;
  assign o_rdata   = r_mem[r_raddr_p1];

endmodule

// File: rtl/memoria_load_param.sv
// Game-state RAM with a hardware initialiser that rewrites every entry to
// INIT_VALUE after reset and on a clear request, one entry per cycle.
module memoria_load_param
  import memoria_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                DEPTH      = DEF_DEPTH,
  parameter int                ADDR_W     = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(DEF_INIT_VALUE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] LAST_EXT = (ADDR_W+1)'(DEPTH-1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_fill_addr;
  logic              r_done;

  logic              w_filling;
  logic              w_fill_last;
  logic              w_addr_ok;
  logic              w_rd_ok;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [ADDR_W-1:0] w_raddr_q;
  logic [DATA_W-1:0] w_rd_data;

  assign w_filling   = (r_state == ST_FILL);
  assign w_fill_last = (r_fill_addr == ADDR_W'(DEPTH-1));
  // Zero-extend so the range check stays meaningful when DEPTH is a power of two.
  assign w_addr_ok   = ({1'b0, addr}      <= LAST_EXT);
  assign w_rd_ok     = ({1'b0, w_raddr_q} <= LAST_EXT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_FILL;
      r_fill_addr <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_FILL: begin
          if (w_fill_last) begin
            r_state     <= ST_IDLE;
            r_fill_addr <= '0;
            r_done      <= 1'b1;
          end else begin
            r_fill_addr <= r_fill_addr + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clear) begin
            r_state     <= ST_FILL;
            r_fill_addr <= '0;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  // User writes are dropped while filling or when a clear is taken.
  assign w_ram_we    = reset_n & (w_filling | (we & ~clear & w_addr_ok));
  assign w_ram_waddr = w_filling ? r_fill_addr : addr;
  assign w_ram_wdata = w_filling ? INIT_VALUE  : data;

  memoria_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_we      (w_ram_we),
    .i_waddr   (w_ram_waddr),
    .i_wdata   (w_ram_wdata),
    .i_raddr   (addr),
    .o_raddr_q (w_raddr_q),
    .o_rdata   (w_rd_data)
  );

  assign busy = ~reset_n | w_filling;
  assign done = reset_n & r_done;
  assign q    = (busy | ~w_rd_ok) ? INIT_VALUE : w_rd_data;

endmodule

// File: tb/tb_memoria_load_param.sv
// Directed bench for memoria_load_param with hand-computed expectations.
module tb_memoria_load_param;

  localparam int         DATA_W = 2;
  localparam int         DEPTH  = 16;
  localparam int         ADDR_W = 4;
  localparam logic [1:0] INIT   = 2'b10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              we;
  logic              clear;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] q;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  memoria_load_param #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .INIT_VALUE (INIT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .clear   (clear),
    .data    (data),
    .addr    (addr),
    .q       (q),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts busy and done cycles over a fixed window.
  task automatic count_pass(input int cycles, output int nbusy, output int ndone);
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < cycles; i++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      step();
    end
  endtask

  task automatic read_all(input string tag, input int exp);
    for (int a = 0; a < DEPTH; a++) begin
      addr = ADDR_W'(a);
      step();
      chk($sformatf("%s[%0d]", tag, a), int'(q), exp);
    end
  endtask

  int nb, nd, last_done, spacing, nidle, ndone6;

  initial begin
    reset_n = 1'b0; we = 1'b0; clear = 1'b0; data = '0; addr = '0;

    // 1: reset, first pass, all entries INIT; 3: writes to addr 3 during fill dropped
    step();
    chk("rst_busy", int'(busy), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(q), int'(INIT));
    step();
    reset_n = 1'b1;
    nb = 0; nd = 0;
    for (int i = 0; i < 30; i++) begin
      we   = (i < 4);
      addr = 4'd3;
      data = 2'b11;
      if (busy) begin
        nb++;
        if (i < 4) chk("fill_q_forced", int'(q), int'(INIT));
      end
      if (done) nd++;
      step();
    end
    we = 1'b0;
    chk("p1_busy_cycles", nb, 16);
    chk("p1_done_pulses", nd, 1);
    read_all("p1_rd", int'(INIT));

    // 2: write then read, neighbour untouched
    addr = 4'd5; data = 2'b01; we = 1'b1;
    step();
    we = 1'b0;
    chk("wr5_q", int'(q), 1);
    addr = 4'd6;
    step();
    chk("rd6_q", int'(q), int'(INIT));

    // 4: fill with zeros, then clear carrying a write that must be ignored
    for (int a = 0; a < DEPTH; a++) begin
      addr = ADDR_W'(a); data = 2'b00; we = 1'b1;
      step();
    end
    we = 1'b0;
    addr = 4'd9;
    step();
    chk("zero9_q", int'(q), 0);
    clear = 1'b1; we = 1'b1; addr = 4'd7; data = 2'b01;
    step();
    clear = 1'b0; we = 1'b0;
    chk("clr_busy_next", int'(busy), 1);
    count_pass(30, nb, nd);
    chk("p4_busy_cycles", nb, 16);
    chk("p4_done_pulses", nd, 1);
    read_all("p4_rd", int'(INIT));

    // 5: reset in the middle of a pass
    clear = 1'b1;
    step();
    clear = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) nd++;
      step();
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    count_pass(30, nb, ndone6);
    chk("p5_busy_cycles", nb, 16);
    chk("p5_done_pulses", nd + ndone6, 1);

    // 6: clear held high -> back-to-back passes
    clear = 1'b1;
    last_done = -1; spacing = 0; nidle = 0; ndone6 = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (!busy) nidle++;
      if (done) begin
        ndone6++;
        if (last_done >= 0) spacing = i - last_done;
        last_done = i;
      end
    end
    clear = 1'b0;
    chk("p6_done_pulses", ndone6, 2);
    chk("p6_spacing", spacing, 17);
    chk("p6_idle_cycles", nidle, 2);
    nd = 0;
    for (int i = 0; i < 30 && busy; i++) begin
      if (done) nd++;
      step();
    end
    chk("p6_settled", int'(busy), 0);
    addr = 4'd5;
    step();
    chk("p6_rd5", int'(q), int'(INIT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memoria_load_param.md
Name: memoria_load_param

Overview:
- Parametrised single-port synchronous RAM for game state, e.g. per-slot asteroid/sequence codes.
- Has a registered read address, so q follows addr with one cycle of latency.
- Adds a hardware initialiser: after reset, and on a `clear` request, it rewrites every entry to INIT_VALUE, one entry per cycle.
- Sits between the game FSM and datapath; the FSM waits on `busy`/`done` before using the contents.

Parameters:
- DATA_W, 2, width of each entry.
- DEPTH, 16, number of entries; any value ≥ 2.
- ADDR_W, $clog2(DEPTH), address width; derived, do not override.
- INIT_VALUE, 2'b10 (DATA_W bits), value written by the initialiser.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- we  in  1  write enable for user port.
- clear  in  1  request to reinitialise all entries.
- data  in  DATA_W  write data.
- addr  in  ADDR_W  user read/write address.
- q  out  DATA_W  read data, ram[addr_reg].
- busy  out  1  high while initialiser runs.
- done  out  1  one-cycle pulse when an initialisation pass completes.

Behaviour:
- Reset (reset_n=0 sampled at posedge):
  - state←FILL, fill_addr←0, addr_reg←0.
  - Outputs during reset and FILL: busy=1, done=0, q=INIT_VALUE.
  - RAM contents are not reset directly; they are only overwritten by FILL.
- States: FILL, IDLE.
- FILL:
  - Each cycle: ram[fill_addr]←INIT_VALUE, fill_addr←fill_addr+1.
  - On the cycle fill_addr==DEPTH-1, the write happens, state←IDLE, and done=1 during the following cycle only.
  - One pass takes exactly DEPTH cycles; busy falls in the same cycle done rises.
  - `we` and `clear` are ignored in FILL. User writes are dropped, not queued.
  - `addr_reg` still tracks addr, but q is forced to INIT_VALUE while busy.
- IDLE:
  - we=1 → ram[addr]←data at posedge.
  - addr_reg←addr every cycle; q=ram[addr_reg] (combinational from addr_reg).
  - Read latency: 1 cycle from addr to q.
  - Write then read of the same address: q shows the new data in the cycle after the write edge.
- IDLE with clear=1:
  - Next state FILL, fill_addr←0. Any `we` in the same cycle is discarded.
  - busy rises in the next cycle.
- Reset mid-FILL: the pass restarts at fill_addr=0, and done is not emitted for the aborted pass.
- Addresses ≥ DEPTH (only when DEPTH is not a power of two): writes are dropped and q returns INIT_VALUE.
- fill_addr is ADDR_W bits wide and never exceeds DEPTH-1, so there is no wrap-around.
- clear held high continuously: after each pass, IDLE accepts clear again.
  - The result is back-to-back passes with one IDLE cycle between them.
  - done pulses once per pass.

Decomposition:
- Package memoria_pkg:
  - state enum {ST_FILL, ST_IDLE};
  - default DATA_W/DEPTH/INIT_VALUE constants.
- One sub-module, memoria_ram_core:
  - plain RAM array with write port and registered-address read;
  - no initial block.
- Top level holds the FSM, fill counter, write mux (user vs fill) and q override.

Test Plan (DATA_W=2, DEPTH=16, INIT_VALUE=2'b10):
1. Reset for 2 cycles, then release → busy=1 for 16 cycles, done=1 for exactly 1 cycle; afterwards reading addr 0..15 returns 2'b10 for all.
2. IDLE: write 2'b01 to addr 5, then set addr=5 → q=2'b01 one cycle later; addr 6 still reads 2'b10.
3. Write 2'b11 to addr 3 during FILL → write dropped; after done, addr 3 reads 2'b10.
4. Write 2'b00 to addrs 0..15, then pulse clear for one cycle with we=1, addr=7, data=2'b01 → busy for 16 cycles; all entries read 2'b10, including 7.
5. Assert reset_n=0 at fill cycle 8 for 1 cycle → restart from 0; busy lasts 16 more cycles; done pulses once only.
6. Hold clear=1 for 40 cycles from IDLE → done pulses at roughly 17-cycle spacing, and busy drops for 1 cycle between passes.
